// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner
// Turns raw, asynchronous board pins into clean, synchronous, bounce-free
// levels for the GPIO controller's gpio_in bus, plus per-bit change pulses.
// Each bit passes through a multi-flop synchronizer and then a prescaled
// debounce filter. The filter can be bypassed with debounce_en=0.
module gpio_input_conditioner #(
  parameter int INPUT_BITS     = 12,
  parameter int SYNC_STAGES    = 2,
  parameter int PRESCALE       = 1000,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INPUT_BITS-1:0] pin_in,
  input  logic                  debounce_en,
  output logic [INPUT_BITS-1:0] gpio_in,
  output logic [INPUT_BITS-1:0] changed,
  output logic                  tick
);

  // Counter widths are at least one bit so PRESCALE=1 and DEBOUNCE_COUNT=1 stay legal.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DB_W = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_COUNT - 1);

  logic [INPUT_BITS-1:0] sync_q [SYNC_STAGES];
  logic [INPUT_BITS-1:0] sync;

  logic [PS_W-1:0]       ps_cnt;
  logic [PS_W-1:0]       ps_next;

  logic [DB_W-1:0]       db_cnt      [INPUT_BITS];
  logic [DB_W-1:0]       db_cnt_next [INPUT_BITS];
  logic [INPUT_BITS-1:0] gpio_next;
  logic [INPUT_BITS-1:0] gpio_q;

  // Synchronizer chain: pin_in enters stage 0, the last stage is the usable level.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= pin_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Next prescaler count: 0..PRESCALE-1 then wrap.
  always_comb begin
    ps_next = ps_cnt + PS_W'(1);
    if (ps_cnt == PS_LAST) begin
      ps_next = '0;
    end
  end

  // Free-running prescaler; tick is registered so it is high exactly while the count sits at its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_cnt <= '0;
      tick   <= 1'b0;
    end else begin
      ps_cnt <= ps_next;
      tick   <= (ps_next == PS_LAST);
    end
  end

  // Per-bit debounce decision: a new level is accepted only after enough consecutive differing samples.
  always_comb begin
    gpio_next = gpio_in;
    for (int i = 0; i < INPUT_BITS; i++) begin
      db_cnt_next[i] = db_cnt[i];
    end
    if (!debounce_en) begin
      gpio_next = sync;
      for (int i = 0; i < INPUT_BITS; i++) begin
        db_cnt_next[i] = '0;
      end
    end else if (tick) begin
      for (int i = 0; i < INPUT_BITS; i++) begin
        if (sync[i] == gpio_in[i]) begin
          db_cnt_next[i] = '0;
        end else if (db_cnt[i] == DB_LAST) begin
          gpio_next[i]   = sync[i];
          db_cnt_next[i] = '0;
        end else begin
          db_cnt_next[i] = db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Conditioned level, debounce counters and the delayed copy used to flag changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_in <= '0;
      gpio_q  <= '0;
      changed <= '0;
      for (int i = 0; i < INPUT_BITS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      gpio_in <= gpio_next;
      gpio_q  <= gpio_in;
      changed <= gpio_in ^ gpio_q;
      for (int i = 0; i < INPUT_BITS; i++) begin
        db_cnt[i] <= db_cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner
// Directed scenarios (reset, clean steps, glitch, bounce, bypass, reset
// mid-count) followed by randomized pin activity. Every cycle the DUT
// outputs are compared with a behavioural model of the conditioner.
module tb_gpio_input_conditioner;

  localparam int W              = 12;
  localparam int SYNC_STAGES    = 2;
  localparam int PRESCALE       = 4;
  localparam int DEBOUNCE_COUNT = 3;
  localparam int LAT_MIN = SYNC_STAGES + (DEBOUNCE_COUNT - 1) * PRESCALE + 1;
  localparam int LAT_MAX = SYNC_STAGES + DEBOUNCE_COUNT * PRESCALE + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pin_in;
  logic         debounce_en;
  logic [W-1:0] gpio_in;
  logic [W-1:0] changed;
  logic         tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] cur_pins;
  logic         cur_en;

  // Reference model state
  logic [W-1:0] pin_hist [$];
  logic [W-1:0] m_gpio;
  logic [W-1:0] m_gprev;
  logic [W-1:0] m_changed;
  logic         m_tick;
  int           m_edges;
  int           streak [W];

  gpio_input_conditioner #(
    .INPUT_BITS    (W),
    .SYNC_STAGES   (SYNC_STAGES),
    .PRESCALE      (PRESCALE),
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pin_in     (pin_in),
    .debounce_en(debounce_en),
    .gpio_in    (gpio_in),
    .changed    (changed),
    .tick       (tick)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock edge of the model: pins seen by the edge, the mode and reset.
  task automatic modelEdge(input logic [W-1:0] pins, input logic en, input logic r);
    logic [W-1:0] sync_seen;
    logic [W-1:0] gpio_before;
    logic         tick_before;
    if (r) begin
      pin_hist.delete();
      for (int s = 0; s < SYNC_STAGES; s++) pin_hist.push_back('0);
      m_gpio    = '0;
      m_gprev   = '0;
      m_changed = '0;
      m_tick    = 1'b0;
      m_edges   = 0;
      for (int b = 0; b < W; b++) streak[b] = 0;
    end else begin
      // the synchronized level is the pin value from SYNC_STAGES edges ago
      sync_seen   = pin_hist[SYNC_STAGES-1];
      gpio_before = m_gpio;
      tick_before = m_tick;
      if (!en) begin
        m_gpio = sync_seen;
        for (int b = 0; b < W; b++) streak[b] = 0;
      end else if (tick_before) begin
        for (int b = 0; b < W; b++) begin
          if (sync_seen[b] == gpio_before[b]) begin
            streak[b] = 0;
          end else begin
            streak[b]++;
            if (streak[b] == DEBOUNCE_COUNT) begin
              m_gpio[b] = sync_seen[b];
              streak[b] = 0;
            end
          end
        end
      end
      m_changed = gpio_before ^ m_gprev;
      m_gprev   = gpio_before;
      pin_hist.push_front(pins);
      void'(pin_hist.pop_back());
      m_edges++;
      m_tick = ((m_edges % PRESCALE) == PRESCALE - 1);
    end
  endtask

  // Drive inputs for one cycle, advance model, then compare all outputs.
  task automatic applyStimulus(input logic [W-1:0] pins, input logic en, input logic r);
    pin_in      = pins;
    debounce_en = en;
    rst         = r;
    @(posedge clk);
    modelEdge(pins, en, r);
    cyc++;
    #1;
    checkOutput("gpio_in", 32'(gpio_in), 32'(m_gpio));
    checkOutput("changed", 32'(changed), 32'(m_changed));
    checkOutput("tick",    32'(tick),    32'(m_tick));
  endtask

  // Clean step on one pin in debounced mode, with latency window and pulse count.
  task automatic runStep(input int idx, input logic level, input string tag);
    int lat    = -1;
    int pulses = 0;
    int others = 0;
    logic [W-1:0] mask;
    mask = '0;
    mask[idx] = 1'b1;
    cur_pins[idx] = level;
    for (int k = 1; k <= LAT_MAX + 6; k++) begin
      applyStimulus(cur_pins, 1'b1, 1'b0);
      if (lat < 0 && gpio_in[idx] === level) lat = k;
      if (changed[idx] === 1'b1) pulses++;
      if ((changed & ~mask) != '0) others++;
    end
    checkOutput({tag, "_latency_in_window"}, 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
    checkOutput({tag, "_changed_pulses"}, 32'(pulses), 32'd1);
    checkOutput({tag, "_other_bits_quiet"}, 32'(others), 32'd0);
  endtask

  initial begin
    int lat;
    int cnt_a;
    int cnt_b;
    int hold;
    logic prev;
    logic found;
    logic [W-1:0] mask;

    cur_pins = '1;
    cur_en   = 1'b1;

    // 1. Reset with all pins high
    for (int k = 0; k < 3; k++) applyStimulus(cur_pins, cur_en, 1'b1);
    cur_pins = '0;
    for (int k = 0; k < 20; k++) applyStimulus(cur_pins, cur_en, 1'b0);

    // 2. Clean steps on bit 0
    runStep(0, 1'b1, "step_rise");
    runStep(0, 1'b0, "step_fall");

    // 3. Short glitch on bit 3
    cnt_a = 0;
    cnt_b = 0;
    cur_pins[3] = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus(cur_pins, 1'b1, 1'b0);
    cur_pins[3] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(cur_pins, 1'b1, 1'b0);
      if (gpio_in[3] !== 1'b0) cnt_a++;
      if (changed[3] !== 1'b0) cnt_b++;
    end
    checkOutput("glitch_gpio3_high", 32'(cnt_a), 32'd0);
    checkOutput("glitch_changed3",   32'(cnt_b), 32'd0);

    // 4. Bouncing bit 7, then held high
    cnt_a = 0;
    cnt_b = 0;
    prev  = gpio_in[7];
    for (int ph = 0; ph < 6; ph++) begin
      cur_pins[7] = (ph % 2 == 0);
      for (int k = 0; k < 4; k++) begin
        applyStimulus(cur_pins, 1'b1, 1'b0);
        if (gpio_in[7] !== prev) cnt_a++;
        prev = gpio_in[7];
        if (changed[7] === 1'b1) cnt_b++;
      end
    end
    cur_pins[7] = 1'b1;
    for (int k = 0; k < 25; k++) begin
      applyStimulus(cur_pins, 1'b1, 1'b0);
      if (gpio_in[7] !== prev) cnt_a++;
      prev = gpio_in[7];
      if (changed[7] === 1'b1) cnt_b++;
    end
    checkOutput("bounce_transitions", 32'(cnt_a), 32'd1);
    checkOutput("bounce_final_level", 32'(gpio_in[7]), 32'd1);
    checkOutput("bounce_changed_pulses", 32'(cnt_b), 32'd1);

    // 5. Bypass mode: exact latency, then back to debounced mode
    for (int k = 0; k < 5; k++) applyStimulus(cur_pins, 1'b0, 1'b0);
    cur_pins[5] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(cur_pins, 1'b0, 1'b0);
      if (k == 2) checkOutput("bypass_gpio5_edge2", 32'(gpio_in[5]), 32'd0);
      if (k == 3) checkOutput("bypass_gpio5_edge3", 32'(gpio_in[5]), 32'd1);
      if (k == 3) checkOutput("bypass_changed5_edge3", 32'(changed[5]), 32'd0);
      if (k == 4) checkOutput("bypass_changed5_edge4", 32'(changed[5]), 32'd1);
      if (k == 5) checkOutput("bypass_changed5_edge5", 32'(changed[5]), 32'd0);
    end
    cur_pins = '0;
    lat = -1;
    for (int k = 1; k <= LAT_MAX + 4; k++) begin
      applyStimulus(cur_pins, 1'b1, 1'b0);
      if (lat < 0 && gpio_in[5] === 1'b0) lat = k;
    end
    checkOutput("mode_switch_hold_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);

    // 6. Reset in the middle of a debounce count on bit 9
    cur_pins[9] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      applyStimulus(cur_pins, 1'b1, 1'b0);
      if (streak[9] == 2) found = 1'b1;
    end
    checkOutput("midcount_reached", 32'(found), 32'd1);
    checkOutput("midcount_gpio9_before_reset", 32'(gpio_in[9]), 32'd0);
    applyStimulus(cur_pins, 1'b1, 1'b1);
    checkOutput("midcount_gpio9_in_reset", 32'(gpio_in[9]), 32'd0);
    lat = -1;
    for (int k = 1; k <= LAT_MAX + 4; k++) begin
      applyStimulus(cur_pins, 1'b1, 1'b0);
      if (lat < 0 && gpio_in[9] === 1'b1) lat = k;
    end
    checkOutput("midcount_full_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);

    // 7. Randomized pin activity with occasional mode changes and resets
    cur_en = 1'b1;
    for (int seg = 0; seg < 40; seg++) begin
      mask = W'($urandom_range(0, 4095) & $urandom_range(0, 4095));
      cur_pins = cur_pins ^ mask;
      if ($urandom_range(0, 7) == 0) cur_en = ~cur_en;
      if ($urandom_range(0, 19) == 0) applyStimulus(cur_pins, cur_en, 1'b1);
      hold = $urandom_range(1, 16);
      for (int k = 0; k < hold; k++) applyStimulus(cur_pins, cur_en, 1'b0);
    end
    for (int k = 0; k < 40; k++) applyStimulus(cur_pins, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
